// File: rtl/uart_rx_pkg.sv
`timescale 1ns/1ps
// Shared constants for the UART receiver: bus widths, register addresses,
// status bit positions and the receive FSM state type.
package uart_rx_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;

    typedef logic [DATA_W-1:0] data_bus_t;
    typedef logic [ADDR_W-1:0] mem_addr_bus_t;

    localparam mem_addr_bus_t UART_RX_ADDR        = 32'h0000_0400;
    localparam mem_addr_bus_t UART_RX_STATUS_ADDR = 32'h0000_0404;

    localparam int unsigned STAT_NEMPTY    = 0;
    localparam int unsigned STAT_FULL      = 1;
    localparam int unsigned STAT_PERR_ANY  = 2;
    localparam int unsigned STAT_FRAME_ERR = 3;
    localparam int unsigned STAT_OVERRUN   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
// Synchronous FIFO for received entries. A pop frees a slot for a push in
// the same cycle; a push that finds no room is dropped and flagged on o_drop.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 9
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_drop
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    assign o_drop    = i_push && !w_push_ok;

    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (w_pop_ok && !w_push_ok) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// Memory-mapped UART receiver: 8 data bits, even parity, one stop bit.
// Received bytes are queued with their parity-error flag and read over the data-memory port.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] uart_r_addr_i,
    input  logic [ADDR_W-1:0] uart_w_addr_i,
    input  logic              uart_r_enable_i,
    output logic [DATA_W-1:0] uart_data_o,
    output logic              uart_irq_o,
    input  logic              rx
);

    localparam int unsigned DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned S_W   = $clog2(OVERSAMPLE);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [S_W-1:0] S_MID  = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);

    logic              r_rx_meta;
    logic              r_rx_sync;
    logic [DIV_W-1:0]  r_div_cnt;
    logic              w_tick;
    logic              w_start_det;

    rx_state_t         r_state;
    logic [S_W-1:0]    r_s_cnt;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shreg;
    logic              r_perr;
    logic              r_push;
    logic [8:0]        r_push_data;
    logic              r_ferr_set;

    logic [8:0]        w_head;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_drop;
    logic              w_pop;
    logic              w_rd_data;
    logic              w_rd_stat;
    logic [DATA_W-1:0] w_status;

    logic              r_overrun;
    logic              r_frame_err;
    logic              r_perr_any;
    logic [DATA_W-1:0] r_data;
    logic              r_irq;
    logic              w_unused;

    assign w_unused = ^{uart_w_addr_i, w_fifo_count};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    assign w_tick      = (r_div_cnt == DIV_W'(DIV - 1));
    assign w_start_det = w_tick && (r_state == ST_IDLE) && !r_rx_sync;

    // Restarting the divider on start detection keeps bit sampling phase-locked to the frame.
    always_ff @(posedge clk) begin
        if (rst || w_tick || w_start_det) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_s_cnt     <= '0;
            r_bit_idx   <= '0;
            r_shreg     <= '0;
            r_perr      <= 1'b0;
            r_push      <= 1'b0;
            r_push_data <= '0;
            r_ferr_set  <= 1'b0;
        end else begin
            r_push     <= 1'b0;
            r_ferr_set <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!r_rx_sync) begin
                            r_state <= ST_START;
                            r_s_cnt <= '0;
                        end
                    end
                    ST_START: begin
                        if (r_s_cnt == S_MID) begin
                            r_s_cnt   <= '0;
                            r_bit_idx <= '0;
                            r_state   <= r_rx_sync ? ST_IDLE : ST_DATA;
                        end else begin
                            r_s_cnt <= r_s_cnt + S_W'(1);
                        end
                    end
                    ST_DATA: begin
                        r_s_cnt <= r_s_cnt + S_W'(1);
                        if (r_s_cnt == S_LAST) begin
                            r_shreg[r_bit_idx] <= r_rx_sync;
                            r_bit_idx          <= r_bit_idx + 3'd1;
                            if (r_bit_idx == 3'd7) begin
                                r_state <= ST_PARITY;
                            end
                        end
                    end
                    ST_PARITY: begin
                        r_s_cnt <= r_s_cnt + S_W'(1);
                        if (r_s_cnt == S_LAST) begin
                            r_perr  <= r_rx_sync ^ even_parity(r_shreg);
                            r_state <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        r_s_cnt <= r_s_cnt + S_W'(1);
                        if (r_s_cnt == S_LAST) begin
                            if (r_rx_sync) begin
                                r_push      <= 1'b1;
                                r_push_data <= {r_perr, r_shreg};
                            end else begin
                                r_ferr_set <= 1'b1;
                            end
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_push      (r_push),
        .i_push_data (r_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_fifo_count),
        .o_drop      (w_drop)
    );

    assign w_rd_data = uart_r_enable_i && (uart_r_addr_i == UART_RX_ADDR);
    assign w_rd_stat = uart_r_enable_i && (uart_r_addr_i == UART_RX_STATUS_ADDR);
    assign w_pop     = w_rd_data && !w_empty;

    always_comb begin
        w_status                 = '0;
        w_status[STAT_NEMPTY]    = !w_empty;
        w_status[STAT_FULL]      = w_full;
        w_status[STAT_PERR_ANY]  = r_perr_any;
        w_status[STAT_FRAME_ERR] = r_frame_err;
        w_status[STAT_OVERRUN]   = r_overrun;
    end

    // Sticky flags clear on a status read, but a same-cycle set takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data      <= '0;
            r_irq       <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            r_perr_any  <= 1'b0;
        end else begin
            r_irq <= !w_empty;
            if (w_rd_data) begin
                r_data <= w_empty ? '0 : DATA_W'(w_head);
            end else if (w_rd_stat) begin
                r_data <= w_status;
            end
            r_overrun   <= w_drop | (r_overrun & !w_rd_stat);
            r_frame_err <= r_ferr_set | (r_frame_err & !w_rd_stat);
            r_perr_any  <= (r_push & r_push_data[8]) | (r_perr_any & !w_rd_stat);
        end
    end

    assign uart_data_o = r_data;
    assign uart_irq_o  = r_irq;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Directed bench for uart_rx: drives serial frames on rx and checks the register
// interface against hand-computed values. Clock scaled so one bit is 64 clocks.
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int unsigned BIT_CLKS = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] r_addr = '0;
    logic [31:0] w_addr = '0;
    logic        r_en = 1'b0;
    logic [31:0] data_o;
    logic        irq_o;
    logic        rx = 1'b1;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [31:0] rd_val;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ   (614_400),
        .BAUD       (9600),
        .OVERSAMPLE (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .uart_r_addr_i   (r_addr),
        .uart_w_addr_i   (w_addr),
        .uart_r_enable_i (r_en),
        .uart_data_o     (data_o),
        .uart_irq_o      (irq_o),
        .rx              (rx)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((^b) ^ par_flip);
        send_bit(stop_bit);
        rx = 1'b1;
        wait_clks(2 * BIT_CLKS);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        r_addr = a;
        r_en   = 1'b1;
        @(negedge clk);
        r_en   = 1'b0;
        d      = data_o;
    endtask

    initial begin
        wait_clks(4);
        rst = 1'b0;
        wait_clks(2);

        check("reset_data", data_o, 32'h0);
        check("reset_irq", {31'b0, irq_o}, 32'h0);
        rd(UART_RX_STATUS_ADDR, rd_val);
        check("reset_status", rd_val, 32'h0);

        // good byte
        send_frame(8'hA5, 1'b0, 1'b1);
        check("t1_irq_up", {31'b0, irq_o}, 32'h1);
        rd(UART_RX_ADDR, rd_val);
        check("t1_data", rd_val, 32'h0000_00A5);
        wait_clks(2);
        check("t1_irq_down", {31'b0, irq_o}, 32'h0);
        wait_clks(5);
        check("t1_hold", data_o, 32'h0000_00A5);

        // parity error
        send_frame(8'h01, 1'b1, 1'b1);
        rd(UART_RX_ADDR, rd_val);
        check("t2_data", rd_val, 32'h0000_0101);
        rd(UART_RX_STATUS_ADDR, rd_val);
        check("t2_status", rd_val, 32'h0000_0004);
        rd(UART_RX_STATUS_ADDR, rd_val);
        check("t2_status2", rd_val, 32'h0);

        // framing error
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_clks(4 * BIT_CLKS);
        check("t3_irq", {31'b0, irq_o}, 32'h0);
        rd(UART_RX_STATUS_ADDR, rd_val);
        check("t3_status", rd_val, 32'h0000_0008);

        // 3-tick glitch
        rx = 1'b0;
        wait_clks(12);
        rx = 1'b1;
        wait_clks(20 * BIT_CLKS);
        check("t4_irq", {31'b0, irq_o}, 32'h0);
        rd(UART_RX_STATUS_ADDR, rd_val);
        check("t4_status", rd_val, 32'h0);
        send_frame(8'h55, 1'b0, 1'b1);
        rd(UART_RX_ADDR, rd_val);
        check("t4_data", rd_val, 32'h0000_0055);

        // overrun
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        send_frame(8'h33, 1'b0, 1'b1);
        send_frame(8'h44, 1'b0, 1'b1);
        send_frame(8'h55, 1'b0, 1'b1);
        rd(UART_RX_STATUS_ADDR, rd_val);
        check("t5_status", rd_val, 32'h0000_0013);
        rd(UART_RX_ADDR, rd_val);
        check("t5_d0", rd_val, 32'h0000_0011);
        rd(UART_RX_ADDR, rd_val);
        check("t5_d1", rd_val, 32'h0000_0022);
        rd(UART_RX_ADDR, rd_val);
        check("t5_d2", rd_val, 32'h0000_0033);
        rd(UART_RX_ADDR, rd_val);
        check("t5_d3", rd_val, 32'h0000_0044);
        rd(UART_RX_ADDR, rd_val);
        check("t5_empty_read", rd_val, 32'h0);
        rd(UART_RX_STATUS_ADDR, rd_val);
        check("t5_status_after", rd_val, 32'h0);

        // reset mid-frame with a pending entry
        send_frame(8'h99, 1'b0, 1'b1);
        check("t6_irq_pending", {31'b0, irq_o}, 32'h1);
        rd(UART_RX_STATUS_ADDR, rd_val);
        check("t6_status_pending", rd_val, 32'h0000_0001);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rx = 1'b1;
        wait_clks(BIT_CLKS / 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rst_data", data_o, 32'h0);
        check("t6_rst_irq", {31'b0, irq_o}, 32'h0);
        wait_clks(16 * BIT_CLKS);
        check("t6_no_push_irq", {31'b0, irq_o}, 32'h0);
        rd(UART_RX_STATUS_ADDR, rd_val);
        check("t6_status", rd_val, 32'h0);
        send_frame(8'h7E, 1'b0, 1'b1);
        rd(UART_RX_ADDR, rd_val);
        check("t6_data", rd_val, 32'h0000_007E);
        rd(32'h0000_0800, rd_val);
        check("other_addr_hold", rd_val, 32'h0000_007E);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
